// File: rtl/tx_checksum_gen.sv
// LIN frame checksum generator: sums up to 8 data bytes with end-around
// carry and presents the inverted sum, framed as a 10-bit symbol.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   start, pid_in      open a frame (pid_in seeds the sum in enhanced mode)
//   byte_in/valid/last data byte stream, byte_ready accepts
//   cksum_ack          consumer has taken the checksum
//   cksum_valid/out/sym checksum byte and framed symbol
//   byte_count, busy   accepted byte count and non-IDLE flag
//
// Build option: define TX_CKSUM_ENHANCED_EN to seed the sum with pid_in
// (LIN 2.x enhanced checksum); otherwise the classic checksum is built.

module tx_checksum_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pid_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  input  logic       cksum_ack,
  output logic       cksum_valid,
  output logic [7:0] cksum_out,
  output logic [9:0] cksum_sym,
  output logic [3:0] byte_count,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0] state;
  logic [7:0] acc;
  logic [3:0] count;
  logic [7:0] acc_init;
  logic [8:0] sum9;
  logic [7:0] acc_next;
  logic       in_accum;
  logic       in_hold;

`ifdef TX_CKSUM_ENHANCED_EN
  assign acc_init = pid_in;
`else
  logic unused_pid;
  assign unused_pid = ^pid_in;
  assign acc_init   = 8'h00;
`endif

  // End-around carry: folding bit 8 back in cannot overflow,
  // since the largest 9-bit sum is 1FE -> FE + 1 = FF.
  assign sum9     = {1'b0, acc} + {1'b0, byte_in};
  assign acc_next = sum9[7:0] + {7'd0, sum9[8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 8'h00;
      count <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= acc_init;
            count <= 4'd0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (byte_valid) begin
            acc   <= acc_next;
            count <= count + 4'd1;
            // 8th byte closes the frame even without byte_last
            if (byte_last || count == 4'd7) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cksum_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while rst is held, even before
  // the reset edge has returned the FSM to IDLE.
  assign in_accum = (state == ACCUM) && !rst;
  assign in_hold  = (state == HOLD) && !rst;

  assign byte_ready  = in_accum;
  assign cksum_valid = in_hold;
  assign busy        = in_accum || in_hold;
  assign byte_count  = count;
  assign cksum_out   = in_hold ? ~acc : 8'h00;
  assign cksum_sym   = in_hold ? {1'b1, ~acc, 1'b0} : 10'd0;

endmodule

// File: tb/tb_tx_checksum_gen.sv
// Bench for tx_checksum_gen: random frames checked every cycle against a
// queue-based checksum model, plus literal checks of the known vectors.

module tb_tx_checksum_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pid_in;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic       cksum_ack;
  logic       cksum_valid;
  logic [7:0] cksum_out;
  logic [9:0] cksum_sym;
  logic [3:0] byte_count;
  logic       busy;

  int errors = 0;
  int checks = 0;

  tx_checksum_gen dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pid_in      (pid_in),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_last   (byte_last),
    .byte_ready  (byte_ready),
    .cksum_ack   (cksum_ack),
    .cksum_valid (cksum_valid),
    .cksum_out   (cksum_out),
    .cksum_sym   (cksum_sym),
    .byte_count  (byte_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Ones-complement style sum: whenever it passes 255, subtract 255.
  function automatic logic [7:0] ref_cksum(input logic [7:0] init,
                                           input logic [7:0] q[$]);
    int s;
    logic [7:0] r;
    s = int'(init);
    foreach (q[i]) begin
      s += int'(q[i]);
      if (s > 255) s -= 255;
    end
    r = s[7:0];
    return ~r;
  endfunction

  // Model: phase 0 idle, 1 collecting, 2 waiting for ack.
  int         m_phase = 0;
  logic [7:0] m_bytes[$];
  logic [7:0] m_init = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_bytes.delete();
      m_init = 8'h00;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_bytes.delete();
`ifdef TX_CKSUM_ENHANCED_EN
        m_init = pid_in;
`else
        m_init = 8'h00;
`endif
      end
    end else if (m_phase == 1) begin
      if (byte_valid) begin
        m_bytes.push_back(byte_in);
        if (byte_last || m_bytes.size() == 8) m_phase = 2;
      end
    end else begin
      if (cksum_ack) m_phase = 0;
    end
  end

  always @(negedge clk) begin
    logic       ev;
    logic [7:0] ec;
    ev = !rst && m_phase == 2;
    ec = ev ? ref_cksum(m_init, m_bytes) : 8'h00;
    check("byte_ready", byte_ready, !rst && m_phase == 1);
    check("cksum_valid", cksum_valid, ev);
    check("busy", busy, !rst && m_phase != 0);
    check("cksum_out", cksum_out, ec);
    check("cksum_sym", cksum_sym, ev ? {1'b1, ec, 1'b0} : 10'd0);
    check("byte_count", byte_count, m_bytes.size());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] pid,
                      input logic [7:0] q[$],
                      input bit mark_last,
                      input int maxgap);
    start  = 1'b1;
    pid_in = pid;
    tick();
    start  = 1'b0;
    pid_in = 8'($urandom);
    foreach (q[i]) begin
      repeat ($urandom_range(0, maxgap)) begin
        byte_valid = 1'b0;
        start      = ($urandom_range(0, 3) == 0);
        cksum_ack  = ($urandom_range(0, 3) == 0);
        byte_in    = 8'($urandom);
        tick();
      end
      start      = 1'b0;
      cksum_ack  = 1'b0;
      byte_valid = 1'b1;
      byte_in    = q[i];
      byte_last  = mark_last && (i == q.size() - 1);
      tick();
      byte_valid = 1'b0;
      byte_last  = 1'b0;
    end
  endtask

  task automatic ack(input int hold_cycles, input bit with_start);
    repeat (hold_cycles) begin
      byte_valid = ($urandom_range(0, 1) == 1);
      byte_in    = 8'($urandom);
      tick();
    end
    byte_valid = 1'b0;
    cksum_ack  = 1'b1;
    start      = with_start;
    tick();
    cksum_ack  = 1'b0;
    start      = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] pid;
    int         n;
    bit         ml;

    rst = 1'b1; start = 1'b0; pid_in = 8'h00; byte_in = 8'h00;
    byte_valid = 1'b0; byte_last = 1'b0; cksum_ack = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_count", byte_count, 4'd0);
    tick();
    rst = 1'b0;

    q = '{8'h4A, 8'h55, 8'h93, 8'hE5};
    check("model_pin_e6", ref_cksum(8'h00, q), 8'hE6);
    q = '{8'h55, 8'h93, 8'hE5};
    check("model_pin_enh", ref_cksum(8'h4A, q), 8'hE6);

    // Bytes with no start are ignored
    byte_valid = 1'b1; byte_last = 1'b1; byte_in = 8'h77;
    repeat (3) tick();
    byte_valid = 1'b0; byte_last = 1'b0;

`ifdef TX_CKSUM_ENHANCED_EN
    q = '{8'h55, 8'h93, 8'hE5};
    send(8'h4A, q, 1'b1, 2);
    @(negedge clk);
    check("enh_out", cksum_out, 8'hE6);
    check("enh_sym", cksum_sym, 10'h3CC);
    check("enh_count", byte_count, 4'd3);
`else
    q = '{8'h4A, 8'h55, 8'h93, 8'hE5};
    send(8'h00, q, 1'b1, 2);
    @(negedge clk);
    check("cls_out", cksum_out, 8'hE6);
    check("cls_sym", cksum_sym, 10'h3CC);
    check("cls_count", byte_count, 4'd4);
`endif
    check("cls_valid", cksum_valid, 1'b1);
    ack(2, 1'b1);
    @(negedge clk);
    check("ack_start_idle", busy, 1'b0);

    q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send(8'h00, q, 1'b0, 1);
    @(negedge clk);
    check("ff8_out", cksum_out, 8'h00);
    check("ff8_sym", cksum_sym, 10'h200);
    check("ff8_count", byte_count, 4'd8);
    ack(3, 1'b0);

    q = '{8'h00};
    send(8'h00, q, 1'b1, 0);
    repeat (5) begin
      @(negedge clk);
      check("z_out", cksum_out, 8'hFF);
      check("z_sym", cksum_sym, 10'h3FE);
      tick();
    end
    ack(0, 1'b0);
    @(negedge clk);
    check("z_idle_busy", busy, 1'b0);
    check("z_idle_valid", cksum_valid, 1'b0);

    // Abort mid-frame with reset, then a clean frame
    q = '{8'h4A, 8'h55};
    send(8'h00, q, 1'b0, 0);
    rst = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_in = 8'h93;
    tick();
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    check("abort_valid", cksum_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_count", byte_count, 4'd0);
    tick();
    q = '{8'h4A, 8'h55, 8'h93, 8'hE5};
    send(8'h00, q, 1'b1, 3);
    @(negedge clk);
    check("after_abort_out", cksum_out, 8'hE6);
    ack(1, 1'b0);

    repeat (60) begin
      n  = $urandom_range(1, 8);
      ml = (n < 8) ? 1'b1 : bit'($urandom_range(0, 1));
      q.delete();
      repeat (n) q.push_back(8'($urandom));
      pid = 8'($urandom);
      repeat ($urandom_range(0, 2)) begin
        byte_valid = bit'($urandom_range(0, 1));
        cksum_ack  = bit'($urandom_range(0, 1));
        byte_in    = 8'($urandom);
        tick();
      end
      byte_valid = 1'b0;
      cksum_ack  = 1'b0;
      send(pid, q, ml, 3);
      ack($urandom_range(0, 4), bit'($urandom_range(0, 1)));
    end

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
